// File: rtl/axi4_lite_if.sv
`timescale 1ns/1ps
// AXI4-Lite channel bundle shared by an initiator and a target.
interface axi4_lite_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_master.sv
`timescale 1ns/1ps
// AXI4-Lite initiator: one command in flight, registered outputs, and a
// watchdog that flags (but never abandons) a transaction stuck on the slave.
module axi4_lite_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  axi4_lite_if.master         axi
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RSP} state_t;

  state_t              state_q, state_n;
  logic                cmd_ready_q, cmd_ready_n;
  logic                awvalid_q, awvalid_n;
  logic                wvalid_q, wvalid_n;
  logic                bready_q, bready_n;
  logic                arvalid_q, arvalid_n;
  logic                rready_q, rready_n;
  logic                rsp_valid_q, rsp_valid_n;
  logic                write_q, write_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [STRB_W-1:0]   wstrb_q, wstrb_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic [1:0]          resp_q, resp_n;
  logic                timeout_q, timeout_n;
  logic [WDOG_W-1:0]   wdog_q, wdog_n;
  logic                busy_c;

  // State and all output registers; reset drops every VALID/READY at once.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      timeout_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_n;
      cmd_ready_q <= cmd_ready_n;
      awvalid_q   <= awvalid_n;
      wvalid_q    <= wvalid_n;
      bready_q    <= bready_n;
      arvalid_q   <= arvalid_n;
      rready_q    <= rready_n;
      rsp_valid_q <= rsp_valid_n;
      write_q     <= write_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      rdata_q     <= rdata_n;
      resp_q      <= resp_n;
      timeout_q   <= timeout_n;
      wdog_q      <= wdog_n;
    end
  end

  assign busy_c = (state_q == WR) || (state_q == WR_B) ||
                  (state_q == RD_A) || (state_q == RD_D);

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    cmd_ready_n = 1'b0;
    awvalid_n   = awvalid_q;
    wvalid_n    = wvalid_q;
    bready_n    = bready_q;
    arvalid_n   = arvalid_q;
    rready_n    = rready_q;
    rsp_valid_n = rsp_valid_q;
    write_n     = write_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    wstrb_n     = wstrb_q;
    rdata_n     = rdata_q;
    resp_n      = resp_q;
    timeout_n   = timeout_q;
    wdog_n      = wdog_q;

    case (state_q)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_n = 1'b0;
          write_n     = cmd_write;
          addr_n      = cmd_addr;
          wdata_n     = cmd_wdata;
          wstrb_n     = cmd_wstrb;
          rdata_n     = '0;
          resp_n      = 2'b00;
          timeout_n   = 1'b0;
          wdog_n      = '0;
          if (cmd_write) begin
            state_n   = WR;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD_A;
            arvalid_n = 1'b1;
          end
        end
      end
      // AW and W retire independently, in either order.
      WR: begin
        if (awvalid_q && axi.AWREADY) awvalid_n = 1'b0;
        if (wvalid_q && axi.WREADY)   wvalid_n  = 1'b0;
        if ((!awvalid_q || axi.AWREADY) && (!wvalid_q || axi.WREADY)) begin
          state_n  = WR_B;
          bready_n = 1'b1;
        end
      end
      WR_B: begin
        if (axi.BVALID) begin
          resp_n      = axi.BRESP;
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RD_A: begin
        if (axi.ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_D;
        end
      end
      RD_D: begin
        if (axi.RVALID) begin
          rdata_n     = axi.RDATA;
          resp_n      = axi.RRESP;
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Watchdog: saturating count of cycles spent waiting on the slave.
    if ((TIMEOUT != 0) && busy_c && (wdog_q != WDOG_MAX)) begin
      wdog_n = wdog_q + WDOG_W'(1);
      if (wdog_n == WDOG_MAX) timeout_n = 1'b1;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = write_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;

  assign axi.AWADDR  = addr_q;
  assign axi.AWVALID = awvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
`timescale 1ns/1ps
// Bench for axi4_lite_master: delay-programmable slave, word-memory reference
// model, and a scoreboard checked by an independent response monitor.
module tb_axi4_lite_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  always #5 ACLK = ~ACLK;

  axi4_lite_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi4_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .axi(bus)
  );

  typedef struct {
    logic          write;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          to;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  bit            busy = 0;
  int            aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
  logic [1:0]    s_resp;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] smem    [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r = old;
    for (int i = 0; i < int'(SW); i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Slave and response consumer: drive on the falling edge, act on handshakes
  // observed for the rising edge just passed.
  initial begin : drv
    int awc, wc, arc, bc, rc, rspc;
    bit aw_got, w_got, b_act, r_act;
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_rsp;
    logic p_awv, p_wv, p_arv;
    logic [AW-1:0] p_awaddr, p_araddr, waddr, raddr;
    logic [DW-1:0] p_wdata, wd;
    logic [SW-1:0] p_wstrb, ws;
    bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
    rsp_ready = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        awc = 0; wc = 0; arc = 0; bc = 0; rc = 0; rspc = 0;
        aw_got = 0; w_got = 0; b_act = 0; r_act = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0; hs_rsp = 0;
        p_awv = 0; p_wv = 0; p_arv = 0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.ARREADY = 0;
        bus.RVALID = 0; rsp_ready = 0;
        continue;
      end
      if (hs_aw) begin aw_got = 1; awc = 0; chk("awaddr", 64'(waddr), 64'(exp_addr)); end
      if (hs_w)  begin w_got = 1; wc = 0; end
      if (hs_ar) begin r_act = 1; rc = 0; arc = 0; chk("araddr", 64'(raddr), 64'(exp_addr)); end
      if (hs_b)  begin b_act = 0; aw_got = 0; w_got = 0; end
      if (hs_r)  r_act = 0;
      if (hs_rsp) rspc = 0;
      if (aw_got && w_got && !b_act) begin
        smem[waddr] = merge(smem.exists(waddr) ? smem[waddr] : '0, wd, ws);
        b_act = 1; bc = 0;
      end
      if (p_awv && !hs_aw) chk("aw_hold", 64'({bus.AWVALID, bus.AWADDR}), 64'({1'b1, p_awaddr}));
      if (p_wv && !hs_w)   chk("w_hold", 64'({bus.WVALID, bus.WSTRB, bus.WDATA}), 64'({1'b1, p_wstrb, p_wdata}));
      if (p_arv && !hs_ar) chk("ar_hold", 64'({bus.ARVALID, bus.ARADDR}), 64'({1'b1, p_araddr}));

      bus.AWREADY = bus.AWVALID && !aw_got && (awc >= aw_dly);
      if (bus.AWVALID && !aw_got) awc++;
      bus.WREADY = bus.WVALID && !w_got && (wc >= w_dly);
      if (bus.WVALID && !w_got) wc++;
      bus.ARREADY = bus.ARVALID && !r_act && (arc >= ar_dly);
      if (bus.ARVALID && !r_act) arc++;
      bus.BVALID = b_act && (bc >= b_dly);
      bus.BRESP  = bus.BVALID ? s_resp : 2'b00;
      if (b_act) bc++;
      bus.RVALID = r_act && (rc >= r_dly);
      bus.RDATA  = (bus.RVALID && smem.exists(raddr)) ? smem[raddr] : '0;
      bus.RRESP  = bus.RVALID ? s_resp : 2'b00;
      if (r_act) rc++;
      rsp_ready = rsp_valid && (rspc >= rsp_dly);
      if (rsp_valid) rspc++;

      hs_aw = bus.AWVALID && bus.AWREADY; if (hs_aw) waddr = bus.AWADDR;
      hs_w  = bus.WVALID && bus.WREADY;   if (hs_w) begin wd = bus.WDATA; ws = bus.WSTRB; end
      hs_ar = bus.ARVALID && bus.ARREADY; if (hs_ar) raddr = bus.ARADDR;
      hs_b  = bus.BVALID && bus.BREADY;
      hs_r  = bus.RVALID && bus.RREADY;
      hs_rsp = rsp_valid && rsp_ready;
      p_awv = bus.AWVALID; p_awaddr = bus.AWADDR;
      p_wv  = bus.WVALID;  p_wdata = bus.WDATA; p_wstrb = bus.WSTRB;
      p_arv = bus.ARVALID; p_araddr = bus.ARADDR;
    end
  end

  // Response monitor: latency on first presentation, stability while stalled,
  // scoreboard compare on the handshake.
  initial begin : mon
    bit seen = 0;
    exp_t e;
    logic [35:0] held;
    forever begin
      @(negedge ACLK);
      #1;
      if (ARESET) begin seen = 0; continue; end
      if (rsp_valid) begin
        chk("cmd_ready_in_rsp", 64'(cmd_ready), 64'(0));
        if (!seen) begin
          if (sb.size() == 0) fail("unexpected_rsp");
          else chk("latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
          held = {rsp_write, rsp_rdata, rsp_resp, rsp_timeout};
          seen = 1;
        end else begin
          chk("rsp_hold", 64'({rsp_write, rsp_rdata, rsp_resp, rsp_timeout}), 64'(held));
        end
        if (rsp_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_write", 64'(rsp_write), 64'(e.write));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
          seen = 0;
          busy = 0;
        end
      end
    end
  end

  task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int d_aw, input int d_w, input int d_b,
                        input int d_ar, input int d_r, input int d_rsp, input logic [1:0] resp);
    exp_t e;
    int n, wait_cyc;
    aw_dly = d_aw; w_dly = d_w; b_dly = d_b; ar_dly = d_ar; r_dly = d_r;
    rsp_dly = d_rsp; s_resp = resp; exp_addr = a;
    wait_cyc = wr ? ((d_aw > d_w ? d_aw : d_w) + d_b + 2) : (d_ar + d_r + 2);
    e.write = wr;
    e.resp  = resp;
    e.to    = (wait_cyc >= int'(TO));
    e.lat   = wait_cyc + 1;
    if (wr) begin
      e.rdata = '0;
      ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : '0, d, s);
    end else begin
      e.rdata = ref_mem.exists(a) ? ref_mem[a] : '0;
    end
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
    if (!cmd_ready) begin
      fail("cmd_accept_timeout");
      cmd_valid = 0;
      return;
    end
    acc_cyc = cyc;
    busy = 1;
    sb.push_back(e);
    @(negedge ACLK);
    cmd_valid = 0;
    n = 0;
    while (busy && n < 400) begin @(negedge ACLK); n++; end
    if (busy) begin
      fail("rsp_wait_timeout");
      busy = 0;
      sb.delete();
    end
  endtask

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; rsp_dly = 0;
    s_resp = 0; exp_addr = 0;
    repeat (3) @(negedge ACLK);
    #1;
    chk("reset_ctrl", 64'({bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY,
                          cmd_ready, rsp_valid, rsp_write, rsp_timeout, rsp_resp}), 64'(0));
    chk("reset_data", 64'({bus.AWADDR, rsp_rdata}), 64'(0));
    @(negedge ACLK);
    ARESET = 0;

    // Zero-wait write then read back.
    do_txn(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00);
    do_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00);
    // W accepted four cycles after AW, then partial-strobe readback.
    do_txn(1, 32'h8, 32'h12345678, 4'hF, 0, 4, 0, 0, 0, 0, 2'b00);
    do_txn(1, 32'h8, 32'hAABBCCDD, 4'h5, 3, 0, 1, 0, 0, 0, 2'b00);
    do_txn(0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00);
    // SLVERR read held while consumer stalls five cycles.
    do_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 1, 5, 2'b10);
    // Watchdog: long AR stall, exact boundary, and a clean read after.
    do_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 20, 0, 0, 2'b00);
    do_txn(0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 3, 3, 0, 2'b00);
    do_txn(0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 3, 2, 0, 2'b00);
    do_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00);

    for (int i = 0; i < 60; i++) begin
      do_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7) * 4), DW'($urandom),
             SW'($urandom_range(1, 15)), $urandom_range(0, 5), $urandom_range(0, 5),
             $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3),
             $urandom_range(0, 3), 2'($urandom_range(0, 3)));
    end

    // Reset while AW/W are outstanding: valids drop at once, no response.
    aw_dly = 30; w_dly = 30; b_dly = 0; exp_addr = 32'h10;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
    for (int n = 0; n < 100 && !cmd_ready; n++) @(negedge ACLK);
    @(negedge ACLK);
    cmd_valid = 0;
    @(negedge ACLK);
    chk("pre_reset_awvalid", 64'({bus.AWVALID, bus.WVALID}), 64'(2'b11));
    #2 ARESET = 1;
    #1 chk("async_reset_valids", 64'({bus.AWVALID, bus.WVALID, rsp_valid}), 64'(0));
    busy = 0;
    sb.delete();
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    repeat (4) @(negedge ACLK);
    chk("no_rsp_after_reset", 64'(rsp_valid), 64'(0));
    do_txn(1, 32'h10, 32'hCAFEF00D, 4'hF, 1, 0, 0, 0, 0, 0, 2'b00);
    do_txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1, 2'b00);
    do_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 1, 1, 0, 2'b01);

    repeat (3) @(negedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
